// File: rtl/mult_div_32bit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU unit: 32-step shift-add multiply or restoring divide into HI/LO.
// Latency 34 cycles start-to-done (2 for divide by zero); start is ignored while busy.
module mult_div_32bit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t      state;
  logic [4:0]  cnt;
  logic        is_div;
  logic        neg_lo;
  logic        neg_hi;
  logic [31:0] m_reg;
  logic [63:0] acc;
  logic [31:0] rem;

  logic        is_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        dz_req;

  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  always_comb begin
    is_signed = ~op[0];
    a_neg     = is_signed & A[31];
    b_neg     = is_signed & B[31];
    a_mag     = a_neg ? (~A + 32'd1) : A;
    b_mag     = b_neg ? (~B + 32'd1) : B;
    dz_req    = op[1] && (B == 32'd0);
  end

  // Multiply: acc = {partial product, remaining multiplier bits}; divide: acc[31:0] shifts dividend out, quotient in.
  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, m_reg} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    div_shift = {rem, acc[31]};
    div_diff  = div_shift - {1'b0, m_reg};
    prod_fix  = neg_lo ? (~acc + 64'd1) : acc;
    quot_fix  = neg_lo ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem_fix   = neg_hi ? (~rem + 32'd1) : rem;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= 5'd0;
      is_div      <= 1'b0;
      neg_lo      <= 1'b0;
      neg_hi      <= 1'b0;
      m_reg       <= 32'd0;
      acc         <= 64'd0;
      rem         <= 32'd0;
      busy        <= 1'b0;
      done        <= 1'b0;
      hi          <= 32'd0;
      lo          <= 32'd0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (state == DONE && busy) begin
            // divide-by-zero path: one busy cycle already spent, now pulse done
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            done <= 1'b0;
            if (start) begin
              busy        <= 1'b1;
              is_div      <= op[1];
              div_by_zero <= 1'b0;
              if (dz_req) begin
                hi          <= A;
                lo          <= 32'hFFFF_FFFF;
                div_by_zero <= 1'b1;
                state       <= DONE;
              end else begin
                state  <= CALC;
                cnt    <= 5'd0;
                neg_lo <= a_neg ^ b_neg;
                neg_hi <= a_neg;
                rem    <= 32'd0;
                if (op[1]) begin
                  m_reg <= b_mag;
                  acc   <= {32'd0, a_mag};
                end else begin
                  m_reg <= a_mag;
                  acc   <= {32'd0, b_mag};
                end
              end
            end else begin
              state <= IDLE;
            end
          end
        end

        CALC: begin
          if (is_div) begin
            if (!div_diff[32]) begin
              rem <= div_diff[31:0];
              acc <= {acc[63:32], acc[30:0], 1'b1};
            end else begin
              rem <= div_shift[31:0];
              acc <= {acc[63:32], acc[30:0], 1'b0};
            end
          end else begin
            acc <= mul_next;
          end
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end

        FIX: begin
          if (is_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_32bit.sv
// Scoreboard bench for mult_div_32bit: stimulus queues expected HI/LO/flag/done-edge, a monitor checks on done.
module tb_mult_div_32bit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        div_by_zero;

  mult_div_32bit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          done_edge;
    string       name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: got done=1 expected no done (hi=%h lo=%h)", hi, lo);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk({e.name, "_hi"}, hi, e.hi);
        chk({e.name, "_lo"}, lo, e.lo);
        chk({e.name, "_dz"}, div_by_zero, e.dz);
        chk({e.name, "_latency_edge"}, edge_cnt, e.done_edge);
        chk({e.name, "_busy_with_done"}, busy, 1'b0);
      end
    end
  end

  // Called at a negedge; returns 1ns after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eh, input logic [31:0] el, input logic edz,
                       input bit push, input string nm);
    exp_t e;
    op = o; A = a; B = b; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk({nm, "_busy_after_accept"}, busy, 1'b1);
    if (push) begin
      e.hi = eh; e.lo = el; e.dz = edz; e.name = nm;
      e.done_edge = edge_cnt + ((o[1] && b == 32'd0) ? 1 : 33);
      q.push_back(e);
    end
  endtask

  // Leaves the caller at the negedge of the done cycle.
  task automatic wait_done(input string nm);
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) break;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no done expected done within 100 cycles", nm);
    end
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] eh, input logic [31:0] el, input logic edz, input string nm);
    issue(o, a, b, eh, el, edz, 1'b1, nm);
    wait_done(nm);
    @(negedge clk);
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_busy"}, busy, 1'b0);
    chk({nm, "_done"}, done, 1'b0);
    chk({nm, "_hi"}, hi, 32'd0);
    chk({nm, "_lo"}, lo, 32'd0);
    chk({nm, "_dz"}, div_by_zero, 1'b0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; A = 32'd0; B = 32'd0;
    repeat (2) @(negedge clk);
    chk_reset_state("reset");
    reset = 1'b0;
    @(negedge clk);

    run(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, "multu_max");
    run(MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, "mult_m3x7");
    run(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, "mult_minxmin");
    run(DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, "div_m7d2");
    run(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0, "div_ovf");
    run(DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0, "div_7dm2");
    run(DIVU,  32'd100,      32'd0,        32'h0000_0064, 32'hFFFF_FFFF, 1'b1, "divu_dz");
    run(MULTU, 32'd3,        32'd5,        32'h0000_0000, 32'h0000_000F, 1'b0, "multu_3x5");
    run(DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, "div_dz_signed");

    // Abort: start 6*7, ignored start while busy, then reset mid-operation.
    issue(MULTU, 32'd6, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0, "abort_op");
    repeat (4) @(negedge clk);
    op = MULT; A = 32'd9; B = 32'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ignored_start_busy", busy, 1'b1);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_state("abort_reset");
    repeat (40) @(negedge clk);
    chk("abort_idle_busy", busy, 1'b0);
    run(MULTU, 32'd6, 32'd7, 32'h0000_0000, 32'h0000_002A, 1'b0, "multu_6x7");

    // Back-to-back: new start presented during the done cycle.
    issue(MULTU, 32'd2, 32'd3, 32'h0000_0000, 32'h0000_0006, 1'b0, 1'b1, "b2b_first");
    wait_done("b2b_first");
    issue(DIVU, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, 1'b0, 1'b1, "b2b_divu");
    wait_done("b2b_divu");
    @(negedge clk);

    issue(DIVU, 32'd1, 32'd0, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b1, "b2b_dz");
    wait_done("b2b_dz");
    issue(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, "b2b_after_dz");
    wait_done("b2b_after_dz");
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_32bit.md
# mult_div_32bit

Iterative 32-bit multiply/divide unit for the processor's execute stage, covering MIPS MULT, MULTU, DIV and DIVU. It runs a radix-2 shift-add multiply or restoring divide over 32 cycles and writes a 64-bit result into the HI/LO registers. LO is the source that the result mux forwards to the 32-bit zero-bit detector downstream. A start/busy/done handshake lets the control unit stall the pipeline while an operation is in flight.

## Interface
- No parameters; the width is fixed at 32 bits.
- `clk`  input  1  the single clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high.
- `start`  input  1  launches an operation. Sampled only while `busy`=0.
- `op`  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU. Sampled with `start`.
- `A`  input  32  operand: multiplicand or dividend. Sampled with `start`.
- `B`  input  32  operand: multiplier or divisor. Sampled with `start`.
- `busy`  output  1  high while an operation is in flight.
- `done`  output  1  one-cycle pulse; `hi`/`lo` are valid from this cycle onward.
- `hi`  output  32  MULT/MULTU: upper product. DIV/DIVU: remainder.
- `lo`  output  32  MULT/MULTU: lower product. DIV/DIVU: quotient.
- `div_by_zero`  output  1  set with `done` on DIV/DIVU with B=0; cleared on the next accepted `start`.

## Operation
- States:
  - IDLE: waits for `start`.
  - CALC: iteration, counter 0..31.
  - FIX: sign correction and HI/LO write.
  - DONE: `done`=1 for one cycle.
- IDLE -> CALC on `start`=1. At that edge the unit latches `op`, loads the magnitudes |A| and |B| for signed ops (raw values for unsigned ops), and records the result signs.
  - Multiply result sign = sign(A) XOR sign(B).
  - Quotient sign = sign(A) XOR sign(B).
  - Remainder sign = sign(A).
- CALC, one step per cycle, 32 steps total:
  - Multiply: 64-bit accumulator, add-then-shift-right.
  - Divide: 33-bit partial remainder, shift-left/trial-subtract/restore.
- CALC -> FIX when the counter reaches 31. FIX negates the results per the latched signs (two's complement, 64-bit for products), writes `hi`/`lo`, and goes to DONE.
- DONE -> IDLE, or directly to CALC if `start`=1 in the DONE cycle (back-to-back accept).
- Divide by zero (DIV/DIVU with B=0): IDLE -> DONE directly. At the accepting edge: `hi`=A, `lo`=32'hFFFFFFFF, `div_by_zero`=1. No iteration.
- Overflow case DIV 0x80000000 / 0xFFFFFFFF: falls out of the magnitude algorithm as `lo`=0x80000000, `hi`=0. No special handling, no flag.
- `hi`/`lo` change only at the FIX edge or the divide-by-zero edge. At all other times they hold their previous result.
- `start` while `busy`=1 is ignored. Operands and `op` are not re-sampled.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0, `div_by_zero`=0, counter=0.
- A `reset` asserted mid-operation aborts at the next edge and restores the reset values. No `done` pulse is produced for the aborted operation.
- Normal latency, with start accepted at edge N:
  - `busy`=1 from edge N.
  - CALC occupies edges N+1..N+32.
  - FIX occurs at edge N+33; `hi`/`lo` update at that edge.
  - `done`=1 and `busy`=0 for the cycle after edge N+33, i.e. 34 cycles from start to done.
- Divide-by-zero latency: `done`=1 in the cycle after edge N+1. `busy`=1 only for the cycle after edge N.
- `busy` and `done` are never high in the same cycle.
- Throughput: one operation per 34 cycles when started back-to-back in the DONE cycle.

## Test plan
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> `done` 34 cycles after start; `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT A=0xFFFFFFFD (-3), B=7 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7), B=2 -> `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1). Then DIV 0x80000000 / 0xFFFFFFFF -> `lo`=0x80000000, `hi`=0, `div_by_zero`=0.
- DIVU A=100, B=0 -> `done` two cycles after `start`; `hi`=0x00000064, `lo`=0xFFFFFFFF, `div_by_zero`=1. The next MULTU 3*5 clears the flag and gives `lo`=15.
- Start MULTU 6*7, pulse `start` with different operands at cycle 5 (ignored), then assert `reset` at cycle 10:
  - After reset: all outputs 0, no `done` pulse.
  - A fresh MULTU 6*7 then gives `lo`=42, `hi`=0.
- Back-to-back: raise `start` (DIVU 100/7) during the `done` cycle of a prior op. The new op is accepted, `busy` rises next edge, and the result is `lo`=14, `hi`=2, 34 cycles later.
